norm_shift_unit: RTL and testbench

Iterative left-normalizer: the inverse of the 64-bit barrel shifter. Instead of shifting by a supplied amount, it computes the shift amount: leading zeros (unsigned) or redundant sign bits (signed). It returns the normalized word together with that count. It sits beside the barrel shifter in the datapath and feeds priority-encode, float-pack and count-leading-zeros paths. It uses a valid/ready handshake on both sides and a binary-search datapath that resolves one count bit per cycle.

---
 rtl/norm_pkg.sv | 19 +
 rtl/norm_step.sv | 47 ++++
 rtl/norm_shift_unit.sv | 119 +++++++++++
 tb/tb_norm_shift_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : norm_pkg
// Description : Shared defaults and FSM state encoding for the normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
package norm_pkg;

   localparam int NORM_WIDTH = 64;
   localparam int NORM_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : norm_pkg
`default_nettype wire

// File: rtl/norm_step.sv
`default_nettype none
// ============================================================================
// Module      : norm_step
// Description : One binary-search step: tests the 2^k-wide leading window and
//               produces the word shifted by 2^k.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_step
   import norm_pkg::*;
#(
   parameter int WIDTH = NORM_WIDTH,
   parameter int CNT_W = NORM_CNT_W,
   parameter int K_W   = $clog2(CNT_W)
) (
   input  logic [WIDTH-1:0] work,
   input  logic [K_W-1:0]   k,
   input  logic             is_signed,
   output logic             hit,
   output logic [WIDTH-1:0] shifted
);

   localparam logic [WIDTH-1:0] C_ONES  = '1;
   localparam logic [CNT_W-1:0] C_ONE_S = 1;

   logic [CNT_W-1:0] w_s;
   logic [WIDTH-1:0] w_mask_u;
   logic [WIDTH-1:0] w_mask_s;
   logic [WIDTH-1:0] w_win_u;
   logic [WIDTH-1:0] w_win_s;

   // Signed windows are one bit wider: the sign bit itself must survive the shift.
   always_comb begin
      w_s      = C_ONE_S << k;
      w_mask_u = ~(C_ONES >> w_s);
      w_mask_s = ~(C_ONES >> (w_s + C_ONE_S));
      w_win_u  = work & w_mask_u;
      w_win_s  = work & w_mask_s;
      if (is_signed) begin
         hit = (w_win_s == '0) || (w_win_s == w_mask_s);
      end else begin
         hit = (w_win_u == '0);
      end
      shifted = work << w_s;
   end

endmodule : norm_step
`default_nettype wire

// File: rtl/norm_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : norm_shift_unit
// Description : Iterative left-normalizer returning the normalized word and
//               its leading-zero / redundant-sign-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_shift_unit
   import norm_pkg::*;
#(
   parameter int WIDTH = NORM_WIDTH,
   parameter int CNT_W = NORM_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_zero
);

   localparam int K_W = $clog2(CNT_W);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] work_q,   work_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [K_W-1:0]   k_q,      k_d;
   logic             signed_q, signed_d;
   logic             zero_q,   zero_d;

   logic             w_hit;
   logic [WIDTH-1:0] w_shifted;

   norm_step #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .K_W   (K_W)
   ) u_step (
      .work      (work_q),
      .k         (k_q),
      .is_signed (signed_q),
      .hit       (w_hit),
      .shifted   (w_shifted)
   );

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      count_d   = count_q;
      k_d       = k_q;
      signed_d  = signed_q;
      zero_d    = zero_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d   = in_data;
               signed_d = in_signed;
               zero_d   = (in_data == '0) || (in_signed && (in_data == '1));
               count_d  = '0;
               k_d      = K_W'(CNT_W - 1);
               state_d  = RUN;
            end
         end
         RUN: begin
            if (w_hit) begin
               work_d       = w_shifted;
               count_d[k_q] = 1'b1;
            end
            if (k_q == '0) begin
               state_d = DONE;
            end else begin
               k_d = k_q - K_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Results are only presented in DONE so idle/running outputs read as zero.
   always_comb begin
      out_data  = (state_q == DONE) ? work_q  : '0;
      out_count = (state_q == DONE) ? count_q : '0;
      out_zero  = (state_q == DONE) && zero_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         work_q   <= '0;
         count_q  <= '0;
         k_q      <= '0;
         signed_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         count_q  <= count_d;
         k_q      <= k_d;
         signed_q <= signed_d;
         zero_q   <= zero_d;
      end
   end

endmodule : norm_shift_unit
`default_nettype wire

// File: tb/tb_norm_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_shift_unit
// Description : Self-checking bench for norm_shift_unit against a clz/clrsb
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_shift_unit;

   localparam int W  = 64;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_signed;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;
   logic          out_zero;

   int n_pass  = 0;
   int n_total = 0;

   norm_shift_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // clz for unsigned, clrsb for signed; degenerate operands saturate at W-1
   function automatic void ref_norm(input logic [W-1:0] d, input logic sgn,
                                    output int cnt, output logic [W-1:0] nd, output logic z);
      logic [W-1:0] ones;
      ones = '1;
      cnt  = 0;
      if (!sgn) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) break;
            cnt++;
         end
      end else begin
         for (int i = W - 2; i >= 0; i--) begin
            if (d[i] != d[W-1]) break;
            cnt++;
         end
      end
      if (cnt > W - 1) cnt = W - 1;
      nd = d << cnt;
      z  = sgn ? ((d == '0) || (d == ones)) : (d == '0);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, W'(out_valid), 0);
      check({tag, "_in_ready"},  W'(in_ready),  1);
      check({tag, "_out_data"},  out_data,      0);
      check({tag, "_out_count"}, W'(out_count), 0);
      check({tag, "_out_zero"},  W'(out_zero),  0);
   endtask

   task automatic accept(input logic [W-1:0] d, input logic sgn);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = sgn;
      @(negedge clk);
      in_valid  = 1'b0;
      in_data   = {$urandom, $urandom};
      in_signed = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Called at a negedge with the unit idle; returns at a negedge, idle again.
   task automatic run_op(input logic [W-1:0] d, input logic sgn, input string tag);
      int           cnt;
      int           lat;
      logic [W-1:0] nd;
      logic         z;
      ref_norm(d, sgn, cnt, nd, z);
      check({tag, "_in_ready"}, W'(in_ready), 1);
      accept(d, sgn);
      wait_valid(lat);
      check({tag, "_latency"}, W'(lat), W'(CW + 1));
      check({tag, "_data"},  out_data,      nd);
      check({tag, "_count"}, W'(out_count), W'(cnt));
      check({tag, "_zero"},  W'(out_zero),  W'(z));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_post_valid"}, W'(out_valid), 0);
   endtask

   initial begin
      int           cnt;
      int           lat;
      int           seen;
      logic [W-1:0] nd;
      logic [W-1:0] ones;
      logic [W-1:0] one;
      logic [W-1:0] d;
      logic         z;
      logic         sgn;

      ones      = '1;
      one       = 1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("reset");

      run_op(64'h0000_0000_0001_0000, 1'b0, "u_bit16");
      run_op(64'hFFFF_FFFF_FFFF_FF80, 1'b1, "s_m128");
      run_op(64'h0000_0000_0000_0071, 1'b1, "s_p71");
      run_op(64'h0,                   1'b0, "u_zero");
      run_op(64'h8000_0000_0000_0071, 1'b0, "u_msb");
      run_op(ones,                    1'b1, "s_allones");
      run_op(64'h0,                   1'b1, "s_zero");

      // Backpressure: result held, second operand refused
      accept(64'h0000_0300_0000_0000, 1'b0);
      wait_valid(lat);
      ref_norm(64'h0000_0300_0000_0000, 1'b0, cnt, nd, z);
      check("bp_latency", W'(lat), W'(CW + 1));
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         @(negedge clk);
         check("bp_hold_valid", W'(out_valid), 1);
         check("bp_hold_data",  out_data,      nd);
         check("bp_hold_count", W'(out_count), W'(cnt));
         check("bp_hold_ready", W'(in_ready),  0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_ready", W'(in_ready),  1);
      check("bp_release_valid", W'(out_valid), 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("bp_no_stray_result", W'(seen), 0);
      run_op(64'h0000_0000_00F0_0000, 1'b0, "b2b_a");
      run_op(64'hFFFF_F000_0000_0000, 1'b1, "b2b_b");

      // Reset during RUN
      accept(64'h0000_0000_0000_1234, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rst_run");
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst_run_no_result", W'(seen), 0);

      // Reset during DONE
      accept(64'h0000_0000_0000_0001, 1'b0);
      wait_valid(lat);
      check("rst_done_reached", W'(out_valid), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rst_done");
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst_done_no_result", W'(seen), 0);
      run_op(64'h0000_0000_0000_0071, 1'b1, "after_rst");

      // Single-bit and sign-boundary patterns, both modes
      for (int i = 0; i < W; i++) begin
         run_op(one << i,    1'b0, "single_u");
         run_op(one << i,    1'b1, "single_s");
         run_op(ones << i,   1'b1, "neg_bound");
         run_op(ones >> i,   1'b1, "pos_bound");
      end

      // Random operands with spread of leading-run lengths
      for (int n = 0; n < 1500; n++) begin
         d   = {$urandom, $urandom};
         d   = d >> $urandom_range(0, W);
         sgn = 1'($urandom);
         if ($urandom_range(0, 1) == 1) d = ~d;
         run_op(d, sgn, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_norm_shift_unit
`default_nettype wire
